// File: rtl/ysyx_23060221_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding,
// funct3 access-size constants and the alignment rule.
package ysyx_23060221_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        OUT  = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // funct3[1:0] carries the access size; bit 2 only selects zero-extension.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] offset);
        logic bad;
        case (f3[1:0])
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = offset[0];
            default: bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_23060221_lsu_align.sv
// Combinational lane logic: store byte-enables and data replication,
// load lane selection with sign/zero extension, and misalignment detection.
module ysyx_23060221_LsuAlign
    import ysyx_23060221_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wmask = 4'b0000;
        wdata = 32'h0;
        case (funct3[1:0])
            SZ_B: begin
                wmask = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            SZ_H: begin
                wmask = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

    assign misalign = is_misaligned(funct3, offset);

endmodule

// File: rtl/ysyx_23060221_lsu.sv
// Load/store stage between execute and writeback: one transaction at a time,
// IDLE accepts, BUS waits for the memory ack, OUT holds the result for writeback.
module ysyx_23060221_lsu
    import ysyx_23060221_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        EXU_valid,
    output logic        LSU_ready,
    input  logic [31:0] res,
    input  logic [31:0] src2,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [2:0]  funct3,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        LSU_valid,
    input  logic        WBU_ready,
    output logic [31:0] lsu_out,
    output logic        lsu_err
);

    lsu_state_t  state;
    lsu_state_t  state_next;

    logic [31:0] addr_q;
    logic [31:0] src2_q;
    logic        ren_q;
    logic        wen_q;
    logic [2:0]  funct3_q;

    logic        accept;
    logic        mem_op;
    logic        in_idle;
    logic        in_bus;

    logic [2:0]  align_funct3;
    logic [1:0]  align_offset;
    logic [3:0]  align_wmask;
    logic [31:0] align_wdata;
    logic [31:0] align_load;
    logic        align_misalign;

    assign in_idle   = (state == IDLE);
    assign in_bus    = (state == BUS);
    assign LSU_ready = in_idle;
    assign LSU_valid = (state == OUT);
    assign accept    = EXU_valid & in_idle;
    assign mem_op    = mem_ren | mem_wen;

    // The alignment check must see the incoming request in IDLE; afterwards
    // everything runs from the latched copy so the bus stays stable.
    assign align_funct3 = in_idle ? funct3    : funct3_q;
    assign align_offset = in_idle ? res[1:0]  : addr_q[1:0];

    ysyx_23060221_LsuAlign u_align (
        .funct3     (align_funct3),
        .offset     (align_offset),
        .store_data (src2_q),
        .rdata      (mem_rdata),
        .wmask      (align_wmask),
        .wdata      (align_wdata),
        .load_data  (align_load),
        .misalign   (align_misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!mem_op || align_misalign) begin
                        state_next = OUT;
                    end else begin
                        state_next = BUS;
                    end
                end
            end
            BUS: begin
                if (mem_ack) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (WBU_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= 32'h0;
            src2_q   <= 32'h0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            funct3_q <= 3'b000;
            lsu_out  <= 32'h0;
            lsu_err  <= 1'b0;
        end else if (accept) begin
            addr_q   <= res;
            src2_q   <= src2;
            ren_q    <= mem_ren;
            wen_q    <= mem_wen;
            funct3_q <= funct3;
            lsu_err  <= 1'b0;
            if (!mem_op) begin
                lsu_out <= res;
            end else if (align_misalign) begin
                lsu_out <= 32'h0;
                lsu_err <= 1'b1;
            end
        end else if (in_bus && mem_ack) begin
            // A set write enable wins over read enable, so such ops report 0.
            lsu_out <= (ren_q && !wen_q) ? align_load : 32'h0;
        end
    end

    assign mem_req   = in_bus;
    assign mem_we    = in_bus & wen_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = align_wdata;
    assign mem_wmask = (in_bus && wen_q) ? align_wmask : 4'b0000;

endmodule

// File: tb/tb_ysyx_23060221_lsu.sv
// Directed bench for the LSU: a vector table of single transactions with
// zero-wait ack, plus hand-written sequences for wait states and reset mid-bus.
module tb_ysyx_23060221_lsu;

    logic        clk;
    logic        rst;
    logic        EXU_valid;
    logic        LSU_ready;
    logic [31:0] res;
    logic [31:0] src2;
    logic        mem_ren;
    logic        mem_wen;
    logic [2:0]  funct3;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        LSU_valid;
    logic        WBU_ready;
    logic [31:0] lsu_out;
    logic        lsu_err;

    int passed;
    int total;

    ysyx_23060221_lsu dut (
        .clk       (clk),
        .rst       (rst),
        .EXU_valid (EXU_valid),
        .LSU_ready (LSU_ready),
        .res       (res),
        .src2      (src2),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .funct3    (funct3),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .LSU_valid (LSU_valid),
        .WBU_ready (WBU_ready),
        .lsu_out   (lsu_out),
        .lsu_err   (lsu_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] src2;
        logic        ren;
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic        exp_bus;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_out;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [31:0] r, input logic [31:0] s,
                                input logic rn, input logic wn, input logic [2:0] f,
                                input logic [31:0] rd, input logic eb, input logic [31:0] ea,
                                input logic [3:0] em, input logic [31:0] ed,
                                input logic [31:0] eo, input logic ee);
        vec_t v;
        v.name = n; v.res = r; v.src2 = s; v.ren = rn; v.wen = wn; v.f3 = f;
        v.rdata = rd; v.exp_bus = eb; v.exp_addr = ea; v.exp_wmask = em;
        v.exp_wdata = ed; v.exp_out = eo; v.exp_err = ee;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // One transaction with WBU_ready high and ack given in the first BUS cycle.
    task automatic applyStimulus(input vec_t v);
        logic        got;
        logic        saw_req;
        int          lat;
        logic [31:0] req_addr;
        logic        req_we;
        logic [3:0]  req_mask;
        logic [31:0] req_wdata;
        got = 1'b0; saw_req = 1'b0; lat = 0;
        req_addr = 32'h0; req_we = 1'b0; req_mask = 4'h0; req_wdata = 32'h0;
        @(negedge clk);
        res = v.res; src2 = v.src2; mem_ren = v.ren; mem_wen = v.wen; funct3 = v.f3;
        mem_rdata = v.rdata; mem_ack = 1'b0; WBU_ready = 1'b1; EXU_valid = 1'b1;
        checkOutput({v.name, " ready"}, {31'h0, LSU_ready}, 32'h1);
        @(posedge clk);
        #1 EXU_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (LSU_valid) begin
                got = 1'b1;
                lat = c;
                break;
            end
            if (mem_req) begin
                if (!saw_req) begin
                    req_addr = mem_addr; req_we = mem_we;
                    req_mask = mem_wmask; req_wdata = mem_wdata;
                end
                saw_req = 1'b1;
                mem_ack = 1'b1;
            end
            @(posedge clk);
            #1 mem_ack = 1'b0;
        end
        if (!got) begin
            checkOutput({v.name, " timeout"}, 32'h0, 32'h1);
        end else begin
            checkOutput({v.name, " latency"}, lat, v.exp_bus ? 32'd2 : 32'd1);
            checkOutput({v.name, " lsu_out"}, lsu_out, v.exp_out);
            checkOutput({v.name, " lsu_err"}, {31'h0, lsu_err}, {31'h0, v.exp_err});
            checkOutput({v.name, " bus_req"}, {31'h0, saw_req}, {31'h0, v.exp_bus});
            if (v.exp_bus) begin
                checkOutput({v.name, " mem_addr"}, req_addr, v.exp_addr);
                checkOutput({v.name, " mem_we"}, {31'h0, req_we}, {31'h0, v.wen});
                if (v.wen) begin
                    checkOutput({v.name, " wmask"}, {28'h0, req_mask}, {28'h0, v.exp_wmask});
                    checkOutput({v.name, " wdata"}, req_wdata, v.exp_wdata);
                end
            end
        end
    endtask

    vec_t vecs[13];

    initial begin
        passed = 0; total = 0;
        rst = 1'b1; EXU_valid = 1'b0; res = 32'h0; src2 = 32'h0; mem_ren = 1'b0;
        mem_wen = 1'b0; funct3 = 3'b000; mem_ack = 1'b0; mem_rdata = 32'h0; WBU_ready = 1'b0;

        vecs[0]  = mk("alu",     32'h1234_5678, 32'h0,         0, 0, 3'b000, 32'h0,         0, 32'h0,         4'h0,    32'h0,         32'h1234_5678, 0);
        vecs[1]  = mk("lb",      32'h8000_0003, 32'h0,         1, 0, 3'b000, 32'h80FF_0000, 1, 32'h8000_0000, 4'h0,    32'h0,         32'hFFFF_FF80, 0);
        vecs[2]  = mk("lbu",     32'h8000_0003, 32'h0,         1, 0, 3'b100, 32'h80FF_0000, 1, 32'h8000_0000, 4'h0,    32'h0,         32'h0000_0080, 0);
        vecs[3]  = mk("sh",      32'h8000_0006, 32'hDEAD_BEEF, 0, 1, 3'b001, 32'h0,         1, 32'h8000_0004, 4'b1100, 32'hBEEF_BEEF, 32'h0,         0);
        vecs[4]  = mk("lw_mis",  32'h8000_0002, 32'h0,         1, 0, 3'b010, 32'h0,         0, 32'h0,         4'h0,    32'h0,         32'h0,         1);
        vecs[5]  = mk("lh",      32'h8000_0002, 32'h0,         1, 0, 3'b001, 32'h8001_7FFF, 1, 32'h8000_0000, 4'h0,    32'h0,         32'hFFFF_8001, 0);
        vecs[6]  = mk("lhu",     32'h8000_0002, 32'h0,         1, 0, 3'b101, 32'h8001_7FFF, 1, 32'h8000_0000, 4'h0,    32'h0,         32'h0000_8001, 0);
        vecs[7]  = mk("sb",      32'h8000_0001, 32'h0000_00A5, 0, 1, 3'b000, 32'h0,         1, 32'h8000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0,         0);
        vecs[8]  = mk("sw",      32'h8000_0010, 32'hCAFE_F00D, 0, 1, 3'b010, 32'h0,         1, 32'h8000_0010, 4'b1111, 32'hCAFE_F00D, 32'h0,         0);
        vecs[9]  = mk("rw_st",   32'h8000_0020, 32'h1122_3344, 1, 1, 3'b010, 32'hFFFF_FFFF, 1, 32'h8000_0020, 4'b1111, 32'h1122_3344, 32'h0,         0);
        vecs[10] = mk("lw",      32'h8000_000C, 32'h0,         1, 0, 3'b010, 32'h1357_9BDF, 1, 32'h8000_000C, 4'h0,    32'h0,         32'h1357_9BDF, 0);
        vecs[11] = mk("sh_mis",  32'h8000_0003, 32'h0000_1234, 0, 1, 3'b001, 32'h0,         0, 32'h0,         4'h0,    32'h0,         32'h0,         1);
        vecs[12] = mk("lb0",     32'h8000_0100, 32'h0,         1, 0, 3'b000, 32'h1234_567F, 1, 32'h8000_0100, 4'h0,    32'h0,         32'h0000_007F, 0);

        repeat (2) @(negedge clk);
        checkOutput("rst LSU_valid", {31'h0, LSU_valid}, 32'h0);
        checkOutput("rst mem_req",   {31'h0, mem_req},   32'h0);
        checkOutput("rst mem_wmask", {28'h0, mem_wmask}, 32'h0);
        checkOutput("rst lsu_out",   lsu_out,            32'h0);
        checkOutput("rst lsu_err",   {31'h0, lsu_err},   32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-rst LSU_ready", {31'h0, LSU_ready}, 32'h1);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
        end

        // lw with the ack arriving in the third BUS cycle, then writeback stalls two cycles.
        @(negedge clk);
        res = 32'h8000_0008; src2 = 32'h0; mem_ren = 1'b1; mem_wen = 1'b0; funct3 = 3'b010;
        mem_rdata = 32'hA5A5_5A5A; WBU_ready = 1'b0; EXU_valid = 1'b1;
        @(posedge clk);
        #1 EXU_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("wait%0d mem_req", c), {31'h0, mem_req}, 32'h1);
            checkOutput($sformatf("wait%0d mem_addr", c), mem_addr, 32'h8000_0008);
            checkOutput($sformatf("wait%0d LSU_valid", c), {31'h0, LSU_valid}, 32'h0);
            if (c == 3) mem_ack = 1'b1;
            @(posedge clk);
            #1 mem_ack = 1'b0;
        end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d LSU_valid", c), {31'h0, LSU_valid}, 32'h1);
            checkOutput($sformatf("stall%0d lsu_out", c), lsu_out, 32'hA5A5_5A5A);
            checkOutput($sformatf("stall%0d LSU_ready", c), {31'h0, LSU_ready}, 32'h0);
            checkOutput($sformatf("stall%0d mem_req", c), {31'h0, mem_req}, 32'h0);
        end
        WBU_ready = 1'b1;
        @(negedge clk);
        checkOutput("release LSU_ready", {31'h0, LSU_ready}, 32'h1);
        checkOutput("release LSU_valid", {31'h0, LSU_valid}, 32'h0);

        // Stray ack while idle must not start anything.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("idle ack LSU_ready", {31'h0, LSU_ready}, 32'h1);
        checkOutput("idle ack LSU_valid", {31'h0, LSU_valid}, 32'h0);

        // Reset in the middle of a BUS transaction, then a late ack.
        res = 32'h8000_0040; mem_ren = 1'b1; mem_wen = 1'b0; funct3 = 3'b010;
        mem_rdata = 32'h7777_7777; EXU_valid = 1'b1;
        @(posedge clk);
        #1 EXU_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre-rst mem_req", {31'h0, mem_req}, 32'h1);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid-rst mem_req",   {31'h0, mem_req},   32'h0);
        checkOutput("mid-rst LSU_valid", {31'h0, LSU_valid}, 32'h0);
        checkOutput("mid-rst lsu_out",   lsu_out,            32'h0);
        checkOutput("mid-rst LSU_ready", {31'h0, LSU_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("late ack LSU_valid", {31'h0, LSU_valid}, 32'h0);
        checkOutput("late ack lsu_out",   lsu_out,            32'h0);
        checkOutput("late ack LSU_ready", {31'h0, LSU_ready}, 32'h1);
        applyStimulus(vecs[1]);
        applyStimulus(vecs[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ysyx_23060221_lsu.md
YSYX_23060221_LSU -- requirements
Module: ysyx_23060221_Lsu

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: EXU_valid  in  1  upstream result valid; LSU_ready  out  1  stage can accept.
REQ-004 SHALL have ports: res  in  32  ALU result or effective address; src2  in  32  store data.
REQ-005 SHALL have ports: mem_ren  in  1  load op; mem_wen  in  1  store op; funct3  in  3  size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-006 SHALL have ports: mem_req  out  1; mem_we  out  1; mem_addr  out  32 (word-aligned); mem_wdata  out  32; mem_wmask  out  4; mem_ack  in  1; mem_rdata  in  32.
REQ-007 SHALL have ports: LSU_valid  out  1; WBU_ready  in  1; lsu_out  out  32  writeback value; lsu_err  out  1  misaligned access flag.

Function
REQ-008 SHALL implement an FSM with states IDLE, BUS, OUT.
REQ-009 SHALL drive LSU_ready=1 only in IDLE; LSU_valid=1 only in OUT.
REQ-010 SHALL accept a transfer when EXU_valid & LSU_ready, latching res, src2, mem_ren, mem_wen, funct3.
REQ-011 SHALL, on accept with mem_ren=mem_wen=0, set lsu_out=res and go IDLE->OUT (LSU_valid one cycle after accept).
REQ-012 SHALL, on accept of an aligned load or store, go IDLE->BUS; mem_req=1 for every BUS cycle, held stable until mem_ack.
REQ-013 SHALL in BUS drive mem_addr={addr[31:2],2'b00}, mem_we=latched mem_wen.
REQ-014 SHALL on mem_ack in BUS go BUS->OUT next edge; zero-wait ack (ack in first BUS cycle) gives LSU_valid two cycles after accept.
REQ-015 SHALL for stores set lsu_out=0; wmask b: 4'b0001<<addr[1:0], h: 4'b0011<<addr[1:0], w: 4'b1111; wdata = src2 byte/half replicated into the addressed lane.
REQ-016 SHALL for loads capture mem_rdata at ack, select lane by addr[1:0], sign-extend (b,h) or zero-extend (bu,hu), w unchanged.
REQ-017 SHALL treat h/hu with addr[0]=1 or w with addr[1:0]!=0 as misaligned: no bus request, IDLE->OUT, lsu_out=0, lsu_err=1.
REQ-018 SHALL hold lsu_out and lsu_err stable throughout OUT until WBU_ready; OUT->IDLE on WBU_ready.
REQ-019 SHALL treat mem_ren&mem_wen both set as a store.
REQ-020 SHALL ignore mem_ack outside BUS and ignore EXU_valid outside IDLE.
REQ-021 SHALL clear lsu_err on the next accept.

Reset
REQ-022 SHALL asynchronously on rst=1 force state=IDLE, LSU_valid=0, mem_req=0, mem_we=0, mem_wmask=0, lsu_out=0, lsu_err=0, LSU_ready=1 after reset release.
REQ-023 SHALL abandon an outstanding BUS transaction on reset; the subsequent late mem_ack is ignored per REQ-020.

Structure
REQ-024 SHALL place funct3 size constants and FSM state encoding in the shared package.
REQ-025 SHALL instantiate one combinational sub-module ysyx_23060221_LsuAlign producing wmask, wdata, load extension and misalign flag.

Verification
REQ-026 SHALL test ALU pass-through: res=0x1234_5678, no mem op, WBU_ready=1 -> LSU_valid one cycle after accept, lsu_out=0x1234_5678, mem_req never 1.
REQ-027 SHALL test lb: addr=0x8000_0003, mem_rdata=0x80FF_0000, zero-wait ack -> lsu_out=0xFFFF_FF80; lbu same -> 0x0000_0080; mem_addr=0x8000_0000.
REQ-028 SHALL test sh: addr=0x8000_0006, src2=0xDEAD_BEEF -> mem_wmask=4'b1100, mem_wdata[31:16]=0xBEEF, mem_we=1, mem_addr=0x8000_0004.
REQ-029 SHALL test 3-cycle ack delay on lw: mem_req/addr stable 3 cycles, LSU_valid only after ack, WBU_ready=0 for 2 cycles holds lsu_out and LSU_ready=0.
REQ-030 SHALL test misaligned lw addr=0x8000_0002 -> no mem_req, LSU_valid next cycle, lsu_err=1, lsu_out=0.
REQ-031 SHALL test rst asserted mid-BUS -> outputs reset immediately, late mem_ack ignored, next accept proceeds normally.
